sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter BATCH, default 4, number of 5-bit sums accumulated per result (legal 1..15).
REQ-002 Parameter ACC_W, default 8, accumulator and result width (legal 6..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  sum_in carries a valid 5-bit sum from the upstream ripple adder.
REQ-006 sum_in  input  5  unsigned sum (0..30) from the upstream adder.
REQ-007 in_ready  output  1  block accepts sum_in this cycle.
REQ-008 out_valid  output  1  acc_out/overflow hold a completed batch result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 acc_out  output  ACC_W  saturated batch total.
REQ-011 overflow  output  1  batch total exceeded 2^ACC_W-1 at least once.

Function
REQ-012 Input transfer SHALL occur when in_valid and in_ready are both high on a rising edge; output transfer when out_valid and out_ready are both high.
REQ-013 FSM states SHALL be IDLE, ACCUM and HOLD.
REQ-014 IDLE: in_ready=1, out_valid=0, accumulator and count 0; an input transfer moves to ACCUM (or straight to HOLD when BATCH=1) with acc=sum_in, count=1.
REQ-015 ACCUM: in_ready=1, out_valid=0; each input transfer adds zero-extended sum_in to acc and increments count.
REQ-016 When the transfer bringing count to BATCH occurs, the FSM SHALL enter HOLD on the same edge, registering the final total.
REQ-017 HOLD: in_ready=0, out_valid=1; acc_out and overflow SHALL stay stable until the output transfer.
REQ-018 On the output transfer the FSM SHALL return to IDLE with acc, count and overflow cleared; in_ready is 1 from the following cycle (no same-cycle accept-and-release).
REQ-019 Latency: out_valid SHALL rise exactly one cycle after the BATCH-th input transfer edge.
REQ-020 Addition SHALL be computed at ACC_W+1 bits; if the carry bit is set, acc SHALL saturate to 2^ACC_W-1 and overflow SHALL be set, sticky for the batch.
REQ-021 in_valid low in ACCUM SHALL hold state indefinitely (bubbles allowed, no timeout).
REQ-022 In HOLD, in_valid high SHALL be ignored and sum_in SHALL not be sampled.
REQ-023 sum_in values above 30 SHALL be accumulated as given (no range check).

Reset
REQ-024 rst high on a rising edge SHALL force IDLE, acc=0, count=0, overflow=0, out_valid=0, in_ready=1 on the next cycle, regardless of state or handshake activity.
REQ-025 rst SHALL take priority over any simultaneous input or output transfer; a partial batch is discarded.

Structure
REQ-026 The FSM state typedef (IDLE/ACCUM/HOLD) and the SUM_W=5 constant SHALL live in a shared package.
REQ-027 The batch count SHALL be a separate sub-module batch_counter (clear, enable, terminal-count flag at BATCH).
REQ-028 Accumulator, saturation and handshake logic SHALL stay in sum_accumulator.

Verification
REQ-029 Defaults, sums 3,5,7,9 back-to-back, out_ready=1 -> out_valid one cycle after 4th transfer, acc_out=24, overflow=0.
REQ-030 ACC_W=6, sums 30,30,30,30 -> acc_out=63, overflow=1.
REQ-031 Sums 1,2,bubble x3,3,4 with out_ready=0 for 5 cycles -> out_valid held, acc_out=10 stable, in_ready=0 throughout HOLD.
REQ-032 rst asserted after 2 of 4 sums (10,10) -> IDLE; next batch 1,1,1,1 gives acc_out=4.
REQ-033 BATCH=1, sum 17 -> out_valid next cycle with acc_out=17; in_ready=0 until output transfer.
REQ-034 In HOLD drive in_valid=1, sum_in=30 for 3 cycles -> acc_out unchanged; next batch unaffected.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: shared state encoding and widths for the batch sum accumulator.
package sum_accumulator_pkg;
    localparam int SUM_W = 5;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/batch_counter.sv
// batch_counter: counts accepted sums; last flags that the next accept completes the batch.
import sum_accumulator_pkg::*;
module batch_counter #(
    parameter int BATCH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end
    assign last = count == CNT_W'(BATCH - 1);
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates BATCH 5-bit sums with saturation and holds the total
// behind a valid/ready handshake until the downstream takes it.
import sum_accumulator_pkg::*;
module sum_accumulator #(
    parameter int BATCH = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] sum_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);
    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic             ovf, ovf_n;
    logic             in_xfer, out_xfer, last;
    logic [ACC_W:0]   sum;

    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign acc_out   = acc;
    assign overflow  = ovf;
    assign sum       = {1'b0, acc} + (ACC_W + 1)'(sum_in);

    batch_counter #(.BATCH(BATCH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (out_xfer),
        .enable (in_xfer),
        .last   (last)
    );

    // acc is zero in IDLE, so the first sum goes through the same adder path
    always_comb begin
        state_n = in_xfer ? (last ? HOLD : ACCUM) : out_xfer ? IDLE : state;
        acc_n   = in_xfer ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : out_xfer ? '0 : acc;
        ovf_n   = in_xfer ? (ovf | sum[ACC_W]) : out_xfer ? 1'b0 : ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ovf   <= ovf_n;
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: three configurations checked against a min(total, max) batch model.
module tb_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] iv, orr, ir, ov, of;
    logic [4:0] si0, si1, si2;
    logic [7:0] a0, a2;
    logic [5:0] a1;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    sum_accumulator u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .sum_in(si0), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .acc_out(a0), .overflow(of[0]));
    sum_accumulator #(.BATCH(4), .ACC_W(6)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .sum_in(si1), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .acc_out(a1), .overflow(of[1]));
    sum_accumulator #(.BATCH(1), .ACC_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .sum_in(si2), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .acc_out(a2), .overflow(of[2]));

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int acc_of(input int i);
        return i == 0 ? int'(a0) : i == 1 ? int'(a1) : int'(a2);
    endfunction

    function automatic int max_of(input int i);
        return i == 1 ? 63 : 255;
    endfunction

    task automatic set_sum(input int i, input int v);
        if (i == 0) si0 = 5'(v);
        else if (i == 1) si1 = 5'(v);
        else si2 = 5'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full batch: gaps[k] bubble cycles before vals[k], then hold_cyc cycles of
    // back-pressure (optionally poking in_valid), then the output transfer.
    task automatic run_batch(input int i, input int vals[$], input int gaps[$],
                             input int hold_cyc, input bit poke);
        int total = 0;
        int exp_acc, exp_of;
        for (int k = 0; k < vals.size(); k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                iv[i] = 1'b0;
                tick();
                check("bubble_out_valid", int'(ov[i]), 0);
                check("bubble_in_ready", int'(ir[i]), 1);
            end
            check("accept_in_ready", int'(ir[i]), 1);
            iv[i] = 1'b1;
            set_sum(i, vals[k]);
            total += vals[k];
            tick();
            iv[i] = 1'b0;
            if (k < vals.size() - 1) check("early_out_valid", int'(ov[i]), 0);
        end
        exp_acc = total > max_of(i) ? max_of(i) : total;
        exp_of  = total > max_of(i) ? 1 : 0;
        check("latency_out_valid", int'(ov[i]), 1);
        check("result_acc", acc_of(i), exp_acc);
        check("result_overflow", int'(of[i]), exp_of);
        check("hold_in_ready", int'(ir[i]), 0);
        for (int h = 0; h < hold_cyc; h++) begin
            orr[i] = 1'b0;
            if (poke) begin
                iv[i] = 1'b1;
                set_sum(i, 30);
            end
            tick();
            check("hold_out_valid", int'(ov[i]), 1);
            check("hold_acc", acc_of(i), exp_acc);
            check("hold_overflow", int'(of[i]), exp_of);
            check("hold_in_ready", int'(ir[i]), 0);
        end
        iv[i]  = 1'b0;
        orr[i] = 1'b1;
        tick();
        orr[i] = 1'b0;
        check("release_out_valid", int'(ov[i]), 0);
        check("release_in_ready", int'(ir[i]), 1);
        check("release_acc", acc_of(i), 0);
        check("release_overflow", int'(of[i]), 0);
    endtask

    initial begin
        int vals[$], gaps[$];
        rst = 1'b1;
        iv  = '0;
        orr = '0;
        si0 = '0;
        si1 = '0;
        si2 = '0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_in_ready", int'(ir[i]), 1);
            check("reset_out_valid", int'(ov[i]), 0);
            check("reset_acc", acc_of(i), 0);
            check("reset_overflow", int'(of[i]), 0);
        end
        rst = 1'b0;

        run_batch(0, '{3, 5, 7, 9}, '{0, 0, 0, 0}, 0, 1'b0);
        run_batch(1, '{30, 30, 30, 30}, '{0, 0, 0, 0}, 0, 1'b0);
        run_batch(0, '{1, 2, 3, 4}, '{0, 0, 3, 0}, 5, 1'b0);
        run_batch(2, '{17}, '{0}, 3, 1'b0);
        run_batch(0, '{6, 6, 6, 6}, '{0, 0, 0, 0}, 3, 1'b1);
        run_batch(0, '{2, 2, 2, 2}, '{0, 0, 0, 0}, 0, 1'b0);

        // partial batch discarded by reset, which also beats a simultaneous transfer
        iv[0] = 1'b1;
        si0   = 5'd10;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        iv[0] = 1'b0;
        check("midreset_in_ready", int'(ir[0]), 1);
        check("midreset_out_valid", int'(ov[0]), 0);
        check("midreset_acc", acc_of(0), 0);
        run_batch(0, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 1'b0);

        // reset while holding a result
        iv[1] = 1'b1;
        si1   = 5'd31;
        repeat (4) tick();
        iv[1] = 1'b0;
        check("prereset_out_valid", int'(ov[1]), 1);
        rst    = 1'b1;
        orr[1] = 1'b1;
        tick();
        rst    = 1'b0;
        orr[1] = 1'b0;
        check("holdreset_out_valid", int'(ov[1]), 0);
        check("holdreset_overflow", int'(of[1]), 0);
        check("holdreset_acc", acc_of(1), 0);

        for (int r = 0; r < 40; r++) begin
            int i = r % 3;
            int n = i == 2 ? 1 : 4;
            vals = {};
            gaps = {};
            for (int k = 0; k < n; k++) begin
                vals.push_back(int'($urandom_range(0, 31)));
                gaps.push_back(int'($urandom_range(0, 2)));
            end
            run_batch(i, vals, gaps, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
